regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle for the register-file arbiter: three write-back sources,
// the register-file write port, destination reservation and hazard query.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned AW    = 5;
    localparam int unsigned REG_N = 32;

    logic              alu_wb_valid;
    logic [AW-1:0]     alu_wb_addr;
    logic [DATA_W-1:0] alu_wb_data;

    logic              lsu_wb_valid;
    logic              lsu_wb_ready;
    logic [AW-1:0]     lsu_wb_addr;
    logic [DATA_W-1:0] lsu_wb_data;

    logic              mdu_wb_valid;
    logic              mdu_wb_ready;
    logic [AW-1:0]     mdu_wb_addr;
    logic [DATA_W-1:0] mdu_wb_data;

    logic              write_ce;
    logic [AW-1:0]     write_addr;
    logic [DATA_W-1:0] write_data;

    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [REG_N-1:0]  busy;

    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    // Pipeline side: drives write-backs, issue and queries.
    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  lsu_wb_ready,
        output mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
        input  mdu_wb_ready,
        input  write_ce, write_addr, write_data,
        output issue_valid, issue_rd,
        input  busy,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy
    );

    // Arbiter side.
    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output lsu_wb_ready,
        input  mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
        output mdu_wb_ready,
        output write_ce, write_addr, write_data,
        input  issue_valid, issue_rd,
        output busy,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU has absolute priority, LSU/MDU share
// the port round-robin; also keeps the per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned REG_N = 32;

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_MDU = 1'b1
    } src_e;

    src_e              r_last_grant;
    logic              r_write_ce;
    logic [AW-1:0]     r_write_addr;
    logic [DATA_W-1:0] r_write_data;
    logic [REG_N-1:0]  r_busy;

    logic              w_lsu_sel;
    logic              w_mdu_sel;
    logic              w_grant;
    logic [AW-1:0]     w_grant_addr;
    logic [DATA_W-1:0] w_grant_data;
    logic              w_grant_wr;
    src_e              w_last_grant_nxt;
    logic [REG_N-1:0]  w_busy_nxt;

    // LSU/MDU selection: only with ALU idle; a tie goes to the source not granted last.
    always_comb begin
        w_lsu_sel = 1'b0;
        w_mdu_sel = 1'b0;
        if (rst_n && !bus.alu_wb_valid) begin
            if (bus.lsu_wb_valid && bus.mdu_wb_valid) begin
                w_lsu_sel = (r_last_grant == SRC_MDU);
                w_mdu_sel = (r_last_grant == SRC_LSU);
            end else begin
                w_lsu_sel = bus.lsu_wb_valid;
                w_mdu_sel = bus.mdu_wb_valid;
            end
        end
    end

    assign bus.lsu_wb_ready = w_lsu_sel;
    assign bus.mdu_wb_ready = w_mdu_sel;

    // Winning write of this cycle and the resulting round-robin pointer.
    always_comb begin
        w_grant          = 1'b0;
        w_grant_addr     = '0;
        w_grant_data     = '0;
        w_last_grant_nxt = r_last_grant;
        if (bus.alu_wb_valid) begin
            w_grant      = 1'b1;
            w_grant_addr = bus.alu_wb_addr;
            w_grant_data = bus.alu_wb_data;
        end else if (w_lsu_sel) begin
            w_grant          = 1'b1;
            w_grant_addr     = bus.lsu_wb_addr;
            w_grant_data     = bus.lsu_wb_data;
            w_last_grant_nxt = SRC_LSU;
        end else if (w_mdu_sel) begin
            w_grant          = 1'b1;
            w_grant_addr     = bus.mdu_wb_addr;
            w_grant_data     = bus.mdu_wb_data;
            w_last_grant_nxt = SRC_MDU;
        end
    end

    // Writes to x0 still complete the handshake but never reach the file.
    assign w_grant_wr = w_grant && (w_grant_addr != AW'(0));

    // Scoreboard update: clear on grant, then set on issue so a collision stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant) begin
            w_busy_nxt[w_grant_addr] = 1'b0;
        end
        if (bus.issue_valid) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SRC_MDU;
            r_write_ce   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_write_ce   <= w_grant_wr;
            if (w_grant_wr) begin
                r_write_addr <= w_grant_addr;
                r_write_data <= w_grant_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.write_ce   = r_write_ce;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
    assign bus.busy       = r_busy;
    assign bus.rs1_busy   = r_busy[bus.rs1_addr];
    assign bus.rs2_busy   = r_busy[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int unsigned DATA_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();
    regfile_wb_arbiter #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit        m_ce;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        m_busy [32];
    bit        m_last_mdu;
    bit        lsu_took;
    bit        mdu_took;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ce = 0; m_addr = 0; m_data = 0; m_last_mdu = 1;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    function automatic void exp_ready(output bit lr, output bit mr);
        lr = 0; mr = 0;
        if (rst_n && !bus.alu_wb_valid) begin
            if (bus.lsu_wb_valid && bus.mdu_wb_valid) begin
                lr = m_last_mdu;
                mr = !m_last_mdu;
            end else begin
                lr = bus.lsu_wb_valid;
                mr = bus.mdu_wb_valid;
            end
        end
    endfunction

    task automatic compare();
        bit lr, mr;
        logic [31:0] bv;
        exp_ready(lr, mr);
        for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
        chk("lsu_ready",  32'(bus.lsu_wb_ready), 32'(lr));
        chk("mdu_ready",  32'(bus.mdu_wb_ready), 32'(mr));
        chk("write_ce",   32'(bus.write_ce), 32'(m_ce));
        chk("write_addr", 32'(bus.write_addr), 32'(m_addr));
        chk("write_data", bus.write_data, m_data);
        chk("busy",       bus.busy, bv);
        chk("rs1_busy",   32'(bus.rs1_busy), 32'(m_busy[bus.rs1_addr]));
        chk("rs2_busy",   32'(bus.rs2_busy), 32'(m_busy[bus.rs2_addr]));
    endtask

    // Inputs are set just after a falling edge; compare, advance model and DUT one cycle.
    task automatic step();
        bit lr, mr, g;
        bit [4:0]  ga;
        bit [31:0] gd;
        #1;
        compare();
        exp_ready(lr, mr);
        g = 0; ga = 0; gd = 0; lsu_took = 0; mdu_took = 0;
        if (bus.alu_wb_valid) begin
            g = 1; ga = bus.alu_wb_addr; gd = bus.alu_wb_data;
        end else if (lr) begin
            g = 1; ga = bus.lsu_wb_addr; gd = bus.lsu_wb_data; lsu_took = 1; m_last_mdu = 0;
        end else if (mr) begin
            g = 1; ga = bus.mdu_wb_addr; gd = bus.mdu_wb_data; mdu_took = 1; m_last_mdu = 1;
        end
        @(posedge clk);
        m_ce = g && (ga != 0);
        if (m_ce) begin
            m_addr = ga;
            m_data = gd;
        end
        if (g) m_busy[ga] = 0;
        if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_wb_valid = 0; bus.alu_wb_addr = 0; bus.alu_wb_data = 0;
        bus.lsu_wb_valid = 0; bus.lsu_wb_addr = 0; bus.lsu_wb_data = 0;
        bus.mdu_wb_valid = 0; bus.mdu_wb_addr = 0; bus.mdu_wb_data = 0;
        bus.issue_valid  = 0; bus.issue_rd = 0;
    endtask

    // LSU/MDU hold a pending write until it is accepted.
    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            bus.alu_wb_valid = ($urandom_range(0, 3) == 0);
            bus.alu_wb_addr  = 5'($urandom);
            bus.alu_wb_data  = $urandom;
            if (!bus.lsu_wb_valid || lsu_took) begin
                bus.lsu_wb_valid = 1'($urandom_range(0, 1));
                bus.lsu_wb_addr  = 5'($urandom);
                bus.lsu_wb_data  = $urandom;
            end
            if (!bus.mdu_wb_valid || mdu_took) begin
                bus.mdu_wb_valid = 1'($urandom_range(0, 1));
                bus.mdu_wb_addr  = 5'($urandom);
                bus.mdu_wb_data  = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd    = 5'($urandom);
            bus.rs1_addr    = 5'($urandom);
            bus.rs2_addr    = 5'($urandom);
            step();
        end
    endtask

    initial begin
        idle();
        bus.rs1_addr = 0; bus.rs2_addr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        compare();
        chk("reset_busy", bus.busy, 32'h0);
        chk("reset_ce", 32'(bus.write_ce), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // ALU-only write, latency one
        bus.alu_wb_valid = 1; bus.alu_wb_addr = 5; bus.alu_wb_data = 32'h1234;
        step();
        chk("alu_ce",   32'(bus.write_ce), 32'h1);
        chk("alu_addr", 32'(bus.write_addr), 32'h5);
        chk("alu_data", bus.write_data, 32'h1234);

        // First tie after reset goes to LSU, then MDU
        idle();
        bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 3; bus.lsu_wb_data = 32'hAAAA_0003;
        bus.mdu_wb_valid = 1; bus.mdu_wb_addr = 4; bus.mdu_wb_data = 32'hBBBB_0004;
        #1;
        chk("tie1_lsu_ready", 32'(bus.lsu_wb_ready), 32'h1);
        chk("tie1_mdu_ready", 32'(bus.mdu_wb_ready), 32'h0);
        step();
        bus.lsu_wb_data = 32'hAAAA_1003;
        #1;
        chk("tie2_lsu_ready", 32'(bus.lsu_wb_ready), 32'h0);
        chk("tie2_mdu_ready", 32'(bus.mdu_wb_ready), 32'h1);
        chk("tie_wr1_addr", 32'(bus.write_addr), 32'h3);
        step();
        chk("tie_wr2_ce",   32'(bus.write_ce), 32'h1);
        chk("tie_wr2_addr", 32'(bus.write_addr), 32'h4);
        chk("tie_wr2_data", bus.write_data, 32'hBBBB_0004);

        // ALU preemption; pointer untouched by ALU writes (last was MDU, so LSU next)
        idle();
        bus.alu_wb_valid = 1; bus.alu_wb_addr = 10; bus.alu_wb_data = 32'h10;
        bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 11; bus.lsu_wb_data = 32'h11;
        bus.mdu_wb_valid = 1; bus.mdu_wb_addr = 12; bus.mdu_wb_data = 32'h12;
        #1;
        chk("pre_lsu_ready", 32'(bus.lsu_wb_ready), 32'h0);
        chk("pre_mdu_ready", 32'(bus.mdu_wb_ready), 32'h0);
        step();
        bus.alu_wb_addr = 13; bus.alu_wb_data = 32'h13;
        step();
        bus.alu_wb_valid = 0;
        #1;
        chk("post_alu_lsu_ready", 32'(bus.lsu_wb_ready), 32'h1);
        step();

        // Scoreboard set by issue, cleared by MDU write-back
        idle();
        bus.issue_valid = 1; bus.issue_rd = 7; bus.rs1_addr = 7;
        step();
        chk("sb_busy7_set", 32'(bus.busy[7]), 32'h1);
        chk("sb_rs1_busy",  32'(bus.rs1_busy), 32'h1);
        idle();
        bus.mdu_wb_valid = 1; bus.mdu_wb_addr = 7; bus.mdu_wb_data = 32'h77;
        step();
        chk("sb_busy7_clr", 32'(bus.busy[7]), 32'h0);
        chk("sb_rs1_clr",   32'(bus.rs1_busy), 32'h0);

        // Set and clear of the same register in one cycle: set wins
        idle();
        bus.issue_valid = 1; bus.issue_rd = 9;
        step();
        bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 9; bus.lsu_wb_data = 32'h99;
        step();
        chk("coll_busy9", 32'(bus.busy[9]), 32'h1);
        chk("coll_ce",    32'(bus.write_ce), 32'h1);
        chk("coll_addr",  32'(bus.write_addr), 32'h9);

        // x0: handshake completes, no write, no reservation
        idle();
        bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 0; bus.lsu_wb_data = 32'hDEAD;
        #1;
        chk("x0_lsu_ready", 32'(bus.lsu_wb_ready), 32'h1);
        step();
        chk("x0_ce",   32'(bus.write_ce), 32'h0);
        chk("x0_hold", bus.write_data, 32'h99);
        idle();
        bus.issue_valid = 1; bus.issue_rd = 0;
        step();
        chk("x0_busy0", 32'(bus.busy[0]), 32'h0);

        idle();
        lsu_took = 0; mdu_took = 0;
        rand_cycles(2000);

        // Asynchronous reset mid-stream
        bus.alu_wb_valid = 1; bus.alu_wb_addr = 21;
        bus.lsu_wb_valid = 1; bus.mdu_wb_valid = 1;
        #2;
        rst_n = 0;
        #1;
        chk("rst_ce",        32'(bus.write_ce), 32'h0);
        chk("rst_addr",      32'(bus.write_addr), 32'h0);
        chk("rst_data",      bus.write_data, 32'h0);
        chk("rst_busy",      bus.busy, 32'h0);
        chk("rst_lsu_ready", 32'(bus.lsu_wb_ready), 32'h0);
        chk("rst_mdu_ready", 32'(bus.mdu_wb_ready), 32'h0);
        model_reset();
        @(negedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_n = 1;
        idle();
        lsu_took = 0; mdu_took = 0;
        rand_cycles(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
